// File: rtl/cp_remover.sv
// rtl/cp_remover.sv - 5G NR receive cyclic-prefix remover
//
// Purpose: strips the cyclic prefix from each of the SYMBOLS OFDM symbols of
// a slot and forwards exactly N useful samples per symbol, tagged with
// in-symbol address, symbol index and start/end flags, one cycle after the
// sample is accepted.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   data_in_r/i              input sample (signed, WIDTH bits each)
//   VALID_IN                 input qualifier; only accepted samples advance state
//   SLOT_START               accepted sample is CP sample 0 of symbol 0
//   data_out_r/i             forwarded useful sample (holds when OUT_VALID=0)
//   OUT_VALID                data_out carries a useful sample
//   sample_address           0..N-1 position within the symbol
//   symbol_index             0..SYMBOLS-1 symbol of the forwarded sample
//   SYMBOL_START/SYMBOL_END  first / last useful sample of a symbol
//   SYNC_ERR                 one-cycle pulse when a slot restarts mid-slot
module cp_remover #(
    parameter int WIDTH   = 26,
    parameter int N       = 2048,
    parameter int CP_NORM = 144,
    parameter int CP_LONG = 160,
    parameter int SYMBOLS = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] data_in_r,
    input  logic signed [WIDTH-1:0] data_in_i,
    input  logic                    VALID_IN,
    input  logic                    SLOT_START,
    output logic signed [WIDTH-1:0] data_out_r,
    output logic signed [WIDTH-1:0] data_out_i,
    output logic                    OUT_VALID,
    output logic [11:0]             sample_address,
    output logic [3:0]              symbol_index,
    output logic                    SYMBOL_START,
    output logic                    SYMBOL_END,
    output logic                    SYNC_ERR
);

    localparam int CPW = $clog2(CP_LONG);
    localparam logic [CPW-1:0] CP_LONG_LAST = CPW'(CP_LONG - 1);
    localparam logic [CPW-1:0] CP_NORM_LAST = CPW'(CP_NORM - 1);
    localparam logic [11:0]    SAMP_LAST    = 12'(N - 1);
    localparam logic [3:0]     SYM_LAST     = 4'(SYMBOLS - 1);
    // Long-CP symbols are the first of each half-slot (0 and 7).
    localparam logic [3:0]     SYM_HALF     = 4'(SYMBOLS / 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP_CP = 2'd1,
        PASS    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CPW-1:0]            cp_cnt_q, cp_cnt_d;
    logic [11:0]               samp_cnt_q, samp_cnt_d;
    logic [3:0]                sym_cnt_q, sym_cnt_d;
    logic signed [WIDTH-1:0]   dout_r_q, dout_r_d;
    logic signed [WIDTH-1:0]   dout_i_q, dout_i_d;
    logic                      out_valid_q, out_valid_d;
    logic [11:0]               addr_q, addr_d;
    logic [3:0]                sym_idx_q, sym_idx_d;
    logic                      sym_start_q, sym_start_d;
    logic                      sym_end_q, sym_end_d;
    logic                      sync_err_q, sync_err_d;
    logic [CPW-1:0]            cp_last;

    always_comb begin
        state_d     = state_q;
        cp_cnt_d    = cp_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;
        addr_d      = addr_q;
        sym_idx_d   = sym_idx_q;
        out_valid_d = 1'b0;
        sym_start_d = 1'b0;
        sym_end_d   = 1'b0;
        sync_err_d  = 1'b0;
        cp_last     = ((sym_cnt_q == 4'd0) || (sym_cnt_q == SYM_HALF)) ? CP_LONG_LAST
                                                                       : CP_NORM_LAST;

        if (VALID_IN) begin
            if (SLOT_START) begin
                // The strobed sample itself is CP sample 0, so counting resumes at 1.
                sync_err_d = (state_q != IDLE);
                state_d    = SKIP_CP;
                sym_cnt_d  = 4'd0;
                cp_cnt_d   = CPW'(1);
                samp_cnt_d = 12'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    SKIP_CP: begin
                        if (cp_cnt_q == cp_last) begin
                            cp_cnt_d   = '0;
                            samp_cnt_d = 12'd0;
                            state_d    = PASS;
                        end else begin
                            cp_cnt_d = cp_cnt_q + CPW'(1);
                        end
                    end
                    PASS: begin
                        out_valid_d = 1'b1;
                        dout_r_d    = data_in_r;
                        dout_i_d    = data_in_i;
                        addr_d      = samp_cnt_q;
                        sym_idx_d   = sym_cnt_q;
                        sym_start_d = (samp_cnt_q == 12'd0);
                        if (samp_cnt_q == SAMP_LAST) begin
                            sym_end_d  = 1'b1;
                            samp_cnt_d = 12'd0;
                            if (sym_cnt_q == SYM_LAST) begin
                                sym_cnt_d = 4'd0;
                                state_d   = IDLE;
                            end else begin
                                sym_cnt_d = sym_cnt_q + 4'd1;
                                state_d   = SKIP_CP;
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + 12'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cp_cnt_q    <= '0;
            samp_cnt_q  <= '0;
            sym_cnt_q   <= '0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            sym_idx_q   <= '0;
            sym_start_q <= 1'b0;
            sym_end_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cp_cnt_q    <= cp_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
            out_valid_q <= out_valid_d;
            addr_q      <= addr_d;
            sym_idx_q   <= sym_idx_d;
            sym_start_q <= sym_start_d;
            sym_end_q   <= sym_end_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign data_out_r     = dout_r_q;
    assign data_out_i     = dout_i_q;
    assign OUT_VALID      = out_valid_q;
    assign sample_address = addr_q;
    assign symbol_index   = sym_idx_q;
    assign SYMBOL_START   = sym_start_q;
    assign SYMBOL_END     = sym_end_q;
    assign SYNC_ERR       = sync_err_q;

endmodule

// File: tb/tb_cp_remover.sv
// tb/tb_cp_remover.sv - self-checking bench for cp_remover
module tb_cp_remover;

    localparam int W = 26;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] data_in_r, data_in_i;
    logic                VALID_IN, SLOT_START;
    logic signed [W-1:0] data_out_r, data_out_i;
    logic                OUT_VALID;
    logic [11:0]         sample_address;
    logic [3:0]          symbol_index;
    logic                SYMBOL_START, SYMBOL_END, SYNC_ERR;

    cp_remover dut (
        .clk(clk), .rst(rst),
        .data_in_r(data_in_r), .data_in_i(data_in_i),
        .VALID_IN(VALID_IN), .SLOT_START(SLOT_START),
        .data_out_r(data_out_r), .data_out_i(data_out_i),
        .OUT_VALID(OUT_VALID), .sample_address(sample_address),
        .symbol_index(symbol_index), .SYMBOL_START(SYMBOL_START),
        .SYMBOL_END(SYMBOL_END), .SYNC_ERR(SYNC_ERR)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Expected held output values (what the outputs show when OUT_VALID=0)
    logic [W-1:0] h_r = '0, h_i = '0;
    logic [11:0]  h_addr = '0;
    logic [3:0]   h_sym = '0;
    logic [71:0]  obs, exp_v;
    int           sync_seen = 0;

    // Reference: where does accepted sample p of a slot fall?
    function automatic void ref_pos(input int p, output bit useful, output int sym, output int addr);
        int base = 0;
        useful = 0; sym = 0; addr = 0;
        for (int s = 0; s < 14; s++) begin
            int cp = (s == 0 || s == 7) ? 160 : 144;
            if (p >= base + cp && p < base + cp + 2048) begin
                useful = 1; sym = s; addr = p - base - cp;
            end
            base += cp + 2048;
        end
    endfunction

    function automatic logic [71:0] mk_exp(input bit v, input bit sync);
        return {v, v && (h_addr == 12'd0), v && (h_addr == 12'd2047), sync, h_addr, h_sym, h_r, h_i};
    endfunction

    task automatic step(input bit v, input bit ss, input logic [W-1:0] r, input logic [W-1:0] i);
        VALID_IN = v; SLOT_START = ss; data_in_r = r; data_in_i = i;
        @(posedge clk); #1;
        obs = {OUT_VALID, SYMBOL_START, SYMBOL_END, SYNC_ERR, sample_address, symbol_index,
               data_out_r, data_out_i};
        if (SYNC_ERR) sync_seen++;
    endtask

    task automatic test_reset();
        bit u; int s, a;
        logic [W-1:0] ri;
        n_cmp++;
        if (obs !== 72'd0) begin n_fail++; $display("FAIL reset_state got %h want 0", obs); end
        rst = 1'b0;
        // Run into symbol 3, address 500 of the PASS phase
        for (int p = 0; p <= 7236; p++) begin
            ri = W'($urandom);
            step(1'b1, p == 0, W'(p), ri);
            ref_pos(p, u, s, a);
            if (u) begin h_r = W'(p); h_i = ri; h_addr = 12'(a); h_sym = 4'(s); end
            exp_v = mk_exp(u, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL pre_reset p=%0d got %h want %h", p, obs, exp_v); end
        end
        n_cmp++;
        if (obs[71] !== 1'b1 || obs[67:56] !== 12'd500 || obs[55:52] !== 4'd3) begin
            n_fail++; $display("FAIL reset_point got %h want valid sym3 addr500", obs);
        end
        rst = 1'b1;
        step(1'b1, 1'b0, W'($urandom), W'($urandom));
        rst = 1'b0;
        h_r = '0; h_i = '0; h_addr = '0; h_sym = '0;
        n_cmp++;
        if (obs !== 72'd0) begin n_fail++; $display("FAIL mid_pass_reset got %h want 0", obs); end
        for (int k = 0; k < 50; k++) begin
            step(1'b1, 1'b0, W'($urandom), W'($urandom));
            n_cmp++;
            if (obs !== 72'd0) begin n_fail++; $display("FAIL post_reset_idle k=%0d got %h want 0", k, obs); end
        end
    endtask

    task automatic test_idle_slot_start_ignored();
        step(1'b0, 1'b1, W'($urandom), W'($urandom));
        n_cmp++;
        if (obs !== 72'd0) begin n_fail++; $display("FAIL idle_ss_novalid got %h want 0", obs); end
        // If the unqualified strobe had started a slot, output would appear after 160 samples
        for (int k = 0; k < 3000; k++) begin
            step(1'b1, 1'b0, W'($urandom), W'($urandom));
            n_cmp++;
            if (obs !== 72'd0) begin n_fail++; $display("FAIL idle_no_output k=%0d got %h want 0", k, obs); end
        end
    endtask

    task automatic test_continuous_slot();
        bit u; int s, a;
        int n_ov = 0, n_st = 0, n_en = 0;
        int first0 = -1, last0 = -1, first1 = -1, first7 = -1;
        logic [W-1:0] ri;
        for (int p = 0; p < 30720; p++) begin
            ri = W'($urandom);
            step(1'b1, p == 0, W'(p), ri);
            ref_pos(p, u, s, a);
            if (u) begin h_r = W'(p); h_i = ri; h_addr = 12'(a); h_sym = 4'(s); end
            exp_v = mk_exp(u, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL slot p=%0d got %h want %h", p, obs, exp_v); end
            if (OUT_VALID) n_ov++;
            if (SYMBOL_START) n_st++;
            if (SYMBOL_END) n_en++;
            if (OUT_VALID && sample_address == 12'd0 && symbol_index == 4'd0) first0 = int'(data_out_r);
            if (OUT_VALID && sample_address == 12'd2047 && symbol_index == 4'd0) last0 = int'(data_out_r);
            if (OUT_VALID && sample_address == 12'd0 && symbol_index == 4'd1) first1 = int'(data_out_r);
            if (OUT_VALID && sample_address == 12'd0 && symbol_index == 4'd7) first7 = int'(data_out_r);
        end
        n_cmp++; if (first0 != 160)   begin n_fail++; $display("FAIL sym0_first got %0d want 160", first0); end
        n_cmp++; if (last0 != 2207)   begin n_fail++; $display("FAIL sym0_last got %0d want 2207", last0); end
        n_cmp++; if (first1 != 2352)  begin n_fail++; $display("FAIL sym1_first got %0d want 2352", first1); end
        n_cmp++; if (first7 != 15520) begin n_fail++; $display("FAIL sym7_first got %0d want 15520", first7); end
        n_cmp++; if (n_ov != 28672)   begin n_fail++; $display("FAIL out_valid_count got %0d want 28672", n_ov); end
        n_cmp++; if (n_st != 14)      begin n_fail++; $display("FAIL symbol_start_count got %0d want 14", n_st); end
        n_cmp++; if (n_en != 14)      begin n_fail++; $display("FAIL symbol_end_count got %0d want 14", n_en); end
    endtask

    // Second slot starts on sample 30720; run up to symbol 5 address 999
    task automatic test_back_to_back();
        bit u; int s, a;
        logic [W-1:0] ri;
        sync_seen = 0;
        for (int p = 0; p < 12120; p++) begin
            ri = W'($urandom);
            step(1'b1, p == 0, W'(p), ri);
            ref_pos(p, u, s, a);
            if (u) begin h_r = W'(p); h_i = ri; h_addr = 12'(a); h_sym = 4'(s); end
            exp_v = mk_exp(u, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL b2b p=%0d got %h want %h", p, obs, exp_v); end
        end
        n_cmp++;
        if (sync_seen != 0) begin n_fail++; $display("FAIL b2b_sync_err got %0d pulses want 0", sync_seen); end
    endtask

    // Restart at symbol 5 address 1000, then continue with a 1-on/2-off valid pattern
    task automatic test_resync_gapped();
        bit u; int s, a;
        logic [W-1:0] ri;
        int dropped = 0;
        bit seen = 0;
        sync_seen = 0;
        step(1'b1, 1'b1, W'(12120), W'($urandom));
        exp_v = mk_exp(1'b0, 1'b1);
        n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL resync_sample got %h want %h", obs, exp_v); end
        for (int p = 1; p <= 2600; p++) begin
            ri = W'($urandom);
            step(1'b1, 1'b0, W'(p), ri);
            ref_pos(p, u, s, a);
            if (u) begin h_r = W'(p); h_i = ri; h_addr = 12'(a); h_sym = 4'(s); end
            exp_v = mk_exp(u, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL gapped p=%0d got %h want %h", p, obs, exp_v); end
            if (!seen && !OUT_VALID) dropped++;
            if (!seen && OUT_VALID) begin
                seen = 1;
                n_cmp++;
                if (symbol_index !== 4'd0 || sample_address !== 12'd0 || data_out_r !== W'(160)) begin
                    n_fail++;
                    $display("FAIL resync_first sym=%0d addr=%0d data=%0d want 0/0/160",
                             symbol_index, sample_address, data_out_r);
                end
            end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 1'($urandom), W'($urandom), W'($urandom));
                exp_v = mk_exp(1'b0, 1'b0);
                n_cmp++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL gap p=%0d g=%0d got %h want %h", p, g, obs, exp_v); end
            end
        end
        n_cmp++; if (dropped != 159) begin n_fail++; $display("FAIL resync_dropped got %0d want 159", dropped); end
        n_cmp++; if (sync_seen != 1) begin n_fail++; $display("FAIL resync_pulses got %0d want 1", sync_seen); end
    endtask

    initial begin
        rst = 1'b1; VALID_IN = 1'b0; SLOT_START = 1'b0; data_in_r = '0; data_in_i = '0;
        step(1'b1, 1'b1, W'($urandom), W'($urandom));
        step(1'b0, 1'b0, '0, '0);
        test_reset();
        test_idle_slot_start_ignored();
        test_continuous_slot();
        test_back_to_back();
        test_resync_gapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cp_remover.md
Name: cp_remover

Overview:
- Receive-side front end of the 5G NR OFDM chain; the inverse of the IFFT + CP insertion path.
- Takes a continuous serial time-domain sample stream, aligned by a slot-start strobe.
- Discards the cyclic prefix of each of the 14 symbols in a slot and forwards exactly N useful samples per symbol, each tagged with a sample address, symbol index and start/end flags.
- Feeds the receive FFT's first-stage input buffer.

Parameters:
- WIDTH, 26, bit width of each real/imag sample.
- N, 2048, useful samples per OFDM symbol (FFT size).
- CP_NORM, 144, CP length for symbols 1-6 and 8-13.
- CP_LONG, 160, CP length for symbols 0 and 7.
- SYMBOLS, 14, symbols per slot.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in_r  in  WIDTH signed  input sample, real.
- data_in_i  in  WIDTH signed  input sample, imag.
- VALID_IN  in  1  input sample qualifier; a sample is accepted only when high.
- SLOT_START  in  1  marks the accepted sample as CP sample 0 of symbol 0; ignored unless VALID_IN is high.
- data_out_r  out  WIDTH signed  forwarded sample, real.
- data_out_i  out  WIDTH signed  forwarded sample, imag.
- OUT_VALID  out  1  data_out is a useful (non-CP) sample.
- sample_address  out  12  index 0..N-1 of the forwarded sample within its symbol.
- symbol_index  out  4  symbol number 0..SYMBOLS-1 of the forwarded sample.
- SYMBOL_START  out  1  high with sample_address 0.
- SYMBOL_END  out  1  high with sample_address N-1.
- SYNC_ERR  out  1  one-cycle pulse on slot resynchronisation mid-slot.

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Internal cp_cnt, samp_cnt and sym_cnt go to 0.
  - Reset wins over every other event in the same cycle.
- Only accepted samples (VALID_IN=1) advance counters. With VALID_IN=0, all counters and state hold.
- Latency: each output is registered. A sample accepted at edge k appears on the outputs after edge k, i.e. 1 cycle latency.
- When OUT_VALID=0: data_out_r/i, sample_address and symbol_index hold their last values. SYMBOL_START and SYMBOL_END are 0.
- FSM states:
  - IDLE:
    - Accepted samples without SLOT_START are dropped.
    - An accepted sample with SLOT_START: sym_cnt=0, the sample counts as CP sample 0, cp_cnt=1, go to SKIP_CP.
  - SKIP_CP:
    - Each accepted sample increments cp_cnt; no output.
    - Current CP length = CP_LONG if sym_cnt is 0 or 7, else CP_NORM.
    - When the last CP sample (cp_cnt = length-1) is accepted: cp_cnt=0, samp_cnt=0, go to PASS.
  - PASS:
    - Each accepted sample is forwarded with sample_address=samp_cnt and symbol_index=sym_cnt; samp_cnt then increments.
    - On samp_cnt=N-1, assert SYMBOL_END and reset samp_cnt to 0.
    - If sym_cnt=SYMBOLS-1, go to IDLE with sym_cnt=0.
    - Otherwise increment sym_cnt and go to SKIP_CP.
- SLOT_START with VALID_IN in SKIP_CP or PASS:
  - The accepted sample becomes CP sample 0 of symbol 0 (sym_cnt=0, cp_cnt=1, state SKIP_CP).
  - No output for that sample.
  - SYNC_ERR pulses for exactly one cycle, aligned with the output slot of that sample.
- SLOT_START on the first accepted sample after symbol 13's last sample (FSM in IDLE) is the normal case: no SYNC_ERR.
- Slot length is exactly 2*(160+2048)+12*(144+2048) = 30720 accepted samples.
- Data path is pass-through with no arithmetic; sign and width are preserved.

Test Plan:
- Reset mid-PASS (symbol 3, address 500): all outputs 0 next cycle; samples without SLOT_START produce no OUT_VALID.
- One full slot with VALID_IN continuously high and data = running sample counter 0..30719:
  - Symbol 0 outputs data 160..2207, addresses 0..2047.
  - Symbol 1 starts at data 2352.
  - Symbol 7 starts at data 15520 (7*2192 + 16 + 160).
  - Exactly 28672 OUT_VALID cycles; SYMBOL_START/SYMBOL_END each pulse 14 times.
- Same slot with VALID_IN toggled in a 1-on/2-off pattern: identical output sequence to the continuous slot; each output is one cycle after its accepted input; no outputs during gaps.
- Back-to-back slots, SLOT_START on sample 30720: second slot identical to the first, SYNC_ERR never asserted.
- SLOT_START asserted at symbol 5, sample_address 1000 of the PASS phase:
  - SYNC_ERR pulses once.
  - That sample is not output.
  - The next 159 samples are dropped (long CP), then symbol_index=0, sample_address=0.
- SLOT_START with VALID_IN=0, then samples in IDLE: no effect, FSM stays IDLE, no OUT_VALID.
